serial_tx_arbiter: RTL and testbench

//  Shares one parallel_serial converter among NUM_REQ word requesters. Round-robin picks a

---
 rtl/serial_arb_pkg.sv | 15 +
 rtl/serial_tx_arbiter_rr.sv | 43 ++++
 rtl/serial_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_serial_tx_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arb_pkg.sv
// Shared types and helpers for the serial transmit arbiter.
package serial_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    // Next round-robin position after id, wrapping at num.
    function automatic int unsigned rr_next(input int unsigned id, input int unsigned num);
        return (id + 32'd1 >= num) ? 32'd0 : id + 32'd1;
    endfunction

endpackage

// File: rtl/serial_tx_arbiter_rr.sv
// Combinational round-robin picker: first request at or after the pointer, wrapping.
module rr_arbiter
    import serial_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ  = 4,
    localparam int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [ID_WIDTH-1:0] i_ptr,
    output logic [NUM_REQ-1:0]  o_grant,
    output logic [ID_WIDTH-1:0] o_id,
    output logic                o_any
);

    localparam logic [ID_WIDTH:0] N_L = (ID_WIDTH + 1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [ID_WIDTH-1:0]  w_idx;
    logic [ID_WIDTH:0]    w_sum;
    logic                 w_found;

    // Rotating the doubled vector puts the pointer position at bit 0.
    assign w_dbl = {i_req, i_req};
    assign w_rot = NUM_REQ'(w_dbl >> i_ptr);

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_idx   = ID_WIDTH'(i);
            end
        end
    end

    assign w_sum   = {1'b0, i_ptr} + {1'b0, w_idx};
    assign o_id    = (w_sum >= N_L) ? ID_WIDTH'(w_sum - N_L) : ID_WIDTH'(w_sum);
    assign o_any   = w_found;
    assign o_grant = w_found ? (NUM_REQ'(1) << o_id) : '0;

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin sharing of one parallel-to-serial converter among NUM_REQ requesters.
// Define SERIAL_ARB_BURST_EN to let an owner keep the converter until req_last_i.
module serial_tx_arbiter
    import serial_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned WORD_WIDTH = 8,
    localparam int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clk_en_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          ser_valid_o,
    input  logic                          ser_ready_i,
    output logic [WORD_WIDTH-1:0]         ser_data_o,
    output logic [ID_WIDTH-1:0]           ser_id_o,
    output logic                          ser_busy_o,
    output logic                          word_done_o
);

    localparam int unsigned CNT_W = $clog2(WORD_WIDTH);

    state_e              r_state;
    logic [ID_WIDTH-1:0] r_ptr;
    logic [ID_WIDTH-1:0] r_gid;
    logic [NUM_REQ-1:0]  r_goh;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_last;

    logic [NUM_REQ-1:0]    w_arb_grant;
    logic [ID_WIDTH-1:0]   w_arb_id;
    logic                  w_arb_any;
    logic                  w_own_valid;
    logic                  w_hs;
    logic                  w_hs_last;
    logic                  w_word_end;
    logic [WORD_WIDTH-1:0] w_mux;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .i_req   (req_valid_i),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_id    (w_arb_id),
        .o_any   (w_arb_any)
    );

`ifdef SERIAL_ARB_BURST_EN
    assign w_hs_last = |(req_last_i & r_goh);
`else
    logic w_unused_last;
    assign w_unused_last = ^req_last_i;
    assign w_hs_last     = 1'b1;
`endif

    assign w_own_valid = |(req_valid_i & r_goh);
    assign w_hs        = (r_state == ST_GRANT) && w_own_valid && ser_ready_i;
    assign w_word_end  = (r_state == ST_SHIFT) && clk_en_i && (r_cnt == '0);

    // One-hot grant selects the owner's word.
    always_comb begin
        w_mux = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (r_goh[k]) begin
                w_mux = w_mux | req_data_i[k*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_gid   <= '0;
            r_goh   <= '0;
            r_cnt   <= '0;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_any) begin
                        r_gid   <= w_arb_id;
                        r_goh   <= w_arb_grant;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!w_own_valid) begin
                        r_state <= ST_IDLE;
                    end else if (ser_ready_i) begin
                        r_cnt   <= CNT_W'(WORD_WIDTH - 1);
                        r_last  <= w_hs_last;
                        r_state <= ST_SHIFT;
                        // Pointer moves only when the owner releases the converter.
                        if (w_hs_last) begin
                            r_ptr <= ID_WIDTH'(rr_next(32'(r_gid), NUM_REQ));
                        end
                    end
                end
                ST_SHIFT: begin
                    if (clk_en_i) begin
                        if (r_cnt == '0) begin
                            r_state <= r_last ? ST_IDLE : ST_GRANT;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ser_valid_o = (r_state == ST_GRANT) && w_own_valid;
    assign req_ready_o = w_hs ? r_goh : '0;
    assign ser_data_o  = (r_state == ST_GRANT) ? w_mux : '0;
    assign ser_busy_o  = (r_state == ST_SHIFT);
    assign ser_id_o    = ser_busy_o ? r_gid : '0;
    assign word_done_o = w_word_end;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter with a behavioural MSB-first converter downstream.
module tb_serial_tx_arbiter;

`ifdef SERIAL_ARB_BURST_EN
    localparam logic [3:0] LAST_DFLT = 4'hF;
`else
    localparam logic [3:0] LAST_DFLT = 4'h0;
`endif

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        ser_valid;
    logic        ser_ready;
    logic [7:0]  ser_data;
    logic [1:0]  ser_id;
    logic        ser_busy;
    logic        word_done;

    logic [7:0]  cv_sh;
    logic [3:0]  cv_cnt;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_done = 0;

    typedef struct {
        logic       en;
        logic [3:0] valid;
        logic [3:0] e_ready;
        logic       e_sval;
        logic [7:0] e_data;
        logic       e_busy;
        logic [1:0] e_id;
        logic       e_done;
        logic       e_bit;
    } vec_t;

    vec_t vq[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    serial_tx_arbiter #(
        .NUM_REQ    (4),
        .WORD_WIDTH (8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clk_en_i    (clk_en),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .ser_valid_o (ser_valid),
        .ser_ready_i (ser_ready),
        .ser_data_o  (ser_data),
        .ser_id_o    (ser_id),
        .ser_busy_o  (ser_busy),
        .word_done_o (word_done)
    );

    // Downstream converter: loads on handshake, shifts MSB first on enabled cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cv_sh  <= 8'h00;
            cv_cnt <= 4'd0;
        end else if (ser_valid && ser_ready) begin
            cv_sh  <= ser_data;
            cv_cnt <= 4'd8;
        end else if (clk_en && cv_cnt != 4'd0) begin
            cv_sh  <= cv_sh << 1;
            cv_cnt <= cv_cnt - 4'd1;
        end
    end
    assign ser_ready = clk_en && (cv_cnt == 4'd0);

    always @(posedge clk) begin
        if (rst_n && word_done) n_done <= n_done + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic en, input logic [3:0] v, input logic [3:0] rdy,
                                input logic sv, input logic [7:0] d, input logic bz,
                                input logic [1:0] id, input logic dn, input logic bt);
        vec_t e;
        e.en = en; e.valid = v; e.e_ready = rdy; e.e_sval = sv; e.e_data = d;
        e.e_busy = bz; e.e_id = id; e.e_done = dn; e.e_bit = bt;
        vq.push_back(e);
    endfunction

    function automatic logic [1:0] oh2id(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input string nm, output logic [1:0] id, output logic [7:0] d,
                           output int cyc);
        logic got = 1'b0;
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (ser_valid && ser_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk({nm, " handshake_seen"}, 32'(got), 32'd1);
        id = oh2id(req_ready);
        d  = ser_data;
    endtask

    task automatic wait_done(input string nm);
        logic got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (word_done) begin
                got = 1'b1;
                break;
            end
        end
        chk({nm, " word_done_seen"}, 32'(got), 32'd1);
    endtask

    initial begin
        logic [7:0] w;
        logic [1:0] id;
        logic [7:0] d;
        int         cyc;
        int         base;

        rst_n     = 1'b0;
        clk_en    = 1'b1;
        req_valid = 4'h0;
        req_last  = LAST_DFLT;
        req_data  = {8'h3C, 8'hA5, 8'h5A, 8'hC3};

        // Single requester 2 with A5, then requester 1 with 5A under a toggling enable.
        w = 8'hA5;
        add(1'b1, 4'b0100, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        add(1'b1, 4'b0100, 4'b0100, 1'b1, 8'hA5, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int b = 0; b < 8; b++)
            add(1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd2, b == 7, w[7-b]);
        add(1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        w = 8'h5A;
        add(1'b1, 4'b0010, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        add(1'b1, 4'b0010, 4'b0010, 1'b1, 8'h5A, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int j = 0; j < 15; j++)
            add((j % 2) == 0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd1, j == 14, w[7-j/2]);
        add(1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        chk("rst busy",  32'(ser_busy),  32'd0);
        chk("rst sval",  32'(ser_valid), 32'd0);
        chk("rst ready", 32'(req_ready), 32'd0);
        chk("rst done",  32'(word_done), 32'd0);
        chk("rst id",    32'(ser_id),    32'd0);
        chk("rst data",  32'(ser_data),  32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vq[i]) begin
            tick();
            clk_en    = vq[i].en;
            req_valid = vq[i].valid;
            @(negedge clk);
            chk($sformatf("vec%0d ready", i), 32'(req_ready), 32'(vq[i].e_ready));
            chk($sformatf("vec%0d sval", i),  32'(ser_valid), 32'(vq[i].e_sval));
            chk($sformatf("vec%0d data", i),  32'(ser_data),  32'(vq[i].e_data));
            chk($sformatf("vec%0d busy", i),  32'(ser_busy),  32'(vq[i].e_busy));
            chk($sformatf("vec%0d id", i),    32'(ser_id),    32'(vq[i].e_id));
            chk($sformatf("vec%0d done", i),  32'(word_done), 32'(vq[i].e_done));
            if (vq[i].e_busy && vq[i].en)
                chk($sformatf("vec%0d serial", i), 32'(cv_sh[7]), 32'(vq[i].e_bit));
        end

        // Reset in the middle of a word from requester 3.
        tick();
        clk_en    = 1'b1;
        req_valid = 4'b1000;
        wait_hs("midrst", id, d, cyc);
        chk("midrst id", 32'(id), 32'd3);
        chk("midrst data", 32'(d), 32'h3C);
        tick();
        req_valid = 4'b0000;
        repeat (3) @(posedge clk);
        #2 chk("midrst busy_before", 32'(ser_busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst busy",  32'(ser_busy),  32'd0);
        chk("midrst sval",  32'(ser_valid), 32'd0);
        chk("midrst ready", 32'(req_ready), 32'd0);
        chk("midrst done",  32'(word_done), 32'd0);
        chk("midrst id0",   32'(ser_id),    32'd0);
        chk("midrst data0", 32'(ser_data),  32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // All four requesting continuously: fair rotation from 0, one word per turn.
        base = n_done;
        tick();
        req_valid = 4'b1111;
        req_last  = LAST_DFLT;
        for (int k = 0; k < 5; k++) begin
            wait_hs($sformatf("rr%0d", k), id, d, cyc);
            chk($sformatf("rr%0d id", k), 32'(id), 32'(k % 4));
            chk($sformatf("rr%0d data", k), 32'(d), 32'(req_data[8*(k%4) +: 8]));
            chk($sformatf("rr%0d words_done", k), 32'(n_done - base), 32'(k));
        end
        tick();
        req_valid = 4'b0000;
        wait_done("rr tail");
        tick();

        // Requester 1 drops valid while granted; pointer must stay at 1.
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        chk("drop ready", 32'(req_ready), 32'd0);
        chk("drop sval",  32'(ser_valid), 32'd0);
        tick();
        req_valid = 4'b1011;
        @(negedge clk);
        chk("drop idle busy", 32'(ser_busy),  32'd0);
        chk("drop idle sval", 32'(ser_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("drop regrant ready", 32'(req_ready), 32'b0010);
        chk("drop regrant data",  32'(ser_data),  32'h5A);
        tick();
        req_valid = 4'b0000;
        wait_done("drop tail");
        tick();

`ifdef SERIAL_ARB_BURST_EN
        // Requester 0 bursts three words while requester 1 waits.
        req_valid     = 4'b0011;
        req_last      = 4'b0000;
        req_data[7:0] = 8'h11;
        wait_hs("burst0", id, d, cyc);
        chk("burst0 id", 32'(id), 32'd0);
        chk("burst0 data", 32'(d), 32'h11);
        tick();
        req_data[7:0] = 8'h22;
        wait_hs("burst1", id, d, cyc);
        chk("burst1 id", 32'(id), 32'd0);
        chk("burst1 data", 32'(d), 32'h22);
        chk("burst1 gap", 32'(cyc), 32'd9);
        tick();
        req_data[7:0] = 8'h33;
        req_last      = 4'b0001;
        wait_hs("burst2", id, d, cyc);
        chk("burst2 id", 32'(id), 32'd0);
        chk("burst2 data", 32'(d), 32'h33);
        chk("burst2 gap", 32'(cyc), 32'd9);
        tick();
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        wait_hs("burst3", id, d, cyc);
        chk("burst3 id", 32'(id), 32'd1);
        chk("burst3 data", 32'(d), 32'h5A);
        chk("burst3 gap", 32'(cyc), 32'd10);
        tick();
        req_valid = 4'b0000;
        wait_done("burst tail");
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
